conv_window_sched: RTL and testbench
====================================

# conv_window_sched

Sequencer for one streamed convolution layer. It counts incoming feature-map pixels by row and column and decides which accepted pixels complete a valid K×K window. It delays that decision through an internal PIPE_LAT-stage valid pipeline so the window strobe lines up with the MAC datapath output, and it frames each image with start/busy/done. It sits between the pixel source (line buffers) and the conv/MAC pipeline, replacing hand-placed fixed delay stages on the valid path.

## Interface
- IMG_W, 28, input feature-map width in pixels (≥ K)
- IMG_H, 28, input feature-map height in pixels (≥ K)
- K, 5, kernel size (≥ 1)
- PIPE_LAT, 3, datapath latency in cycles from pixel acceptance to MAC result (≥ 1)

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE
- pix_valid  input  1  pixel present on the datapath this cycle
- busy  output  1  high in RUN and DRAIN
- col  output  $clog2(IMG_W)  column of the next pixel to be accepted
- row  output  $clog2(IMG_H)  row of the next pixel to be accepted
- win_valid  output  1  datapath output is a valid window result this cycle
- win_last  output  1  with win_valid, marks the final window of the frame
- done  output  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: counters held at 0. start=1 moves to RUN at the next edge. pix_valid is ignored.
- RUN: each cycle with pix_valid=1 accepts one pixel at the current (row, col).
  - Hit = (row ≥ K−1) && (col ≥ K−1).
  - Last = hit && row==IMG_H−1 && col==IMG_W−1.
  - Hit and last are pushed into the valid pipeline. Cycles with pix_valid=0 push 0.
- Counters: col increments on each accept and wraps IMG_W−1→0. A wrap increments row. Accepting pixel (IMG_H−1, IMG_W−1) resets both counters to 0 and moves to DRAIN.
- DRAIN: inputs are ignored and 0 is pushed. The block stays in DRAIN until win_last has been emitted. done=1 is issued in the cycle after win_last, and the state returns to IDLE in that same cycle.
- Valid pipeline: a 2-bit-wide, PIPE_LAT-deep shift register that advances every cycle in all states. win_valid and win_last are its registered outputs.
- Window count per frame: (IMG_W−K+1)·(IMG_H−K+1). Defaults give 576.
- start while busy: ignored with no effect. start in the done cycle: accepted, since the state is already IDLE.
- Reset at any time, including mid-frame or mid-drain: state goes to IDLE, counters and the whole valid pipeline clear, and no stale win_valid appears afterwards.

## Timing
- Reset values: busy=0, row=0, col=0, win_valid=0, win_last=0, done=0.
- start sampled at edge E0 → busy=1 from the cycle after E0. The first pixel can be accepted at edge E0+1.
- Pixel accepted at edge E → its hit appears on win_valid in the cycle after edge E+PIPE_LAT−1. With PIPE_LAT=3 this is 3 registers, the same alignment as a 3-flop valid delay.
- Throughput: one pixel per cycle. Bubbles in pix_valid pass through as gaps in win_valid with no reordering.
- done: high exactly one cycle, the cycle immediately after win_last=1. busy=0 in that same cycle.
- RUN→DRAIN occurs on the accepting edge of the last pixel. DRAIN lasts PIPE_LAT cycles.

## Test plan
- Reset/idle: hold rst_n=0, then release. Pulse pix_valid for 10 cycles without start → all outputs stay 0 and row=col=0.
- Small frame, continuous (IMG_W=IMG_H=4, K=3, PIPE_LAT=3): start, then 16 back-to-back pixels → exactly 4 win_valid pulses, on pixels (2,2), (2,3), (3,2), (3,3), each 3 cycles after acceptance. win_last is set on the 4th. done comes 1 cycle later. busy spans from the cycle after start to the cycle before done.
- Bubbles: same frame with pix_valid toggling 1,0 → still 4 windows, each exactly PIPE_LAT cycles after its own pixel. Counters do not advance on 0 cycles.
- Start handling: start while busy mid-frame → ignored, window count unchanged. start asserted in the done cycle → a second frame runs back-to-back with another 4 windows.
- Reset mid-operation: assert rst_n=0 one cycle after a hit pixel is accepted, still in flight → no win_valid after reset, state IDLE, and the next frame produces a correct 4-window output.
- Default parameters: one full 28×28 frame → 576 win_valid pulses, a single win_last, and a single done.

Source files
------------

// File: rtl/conv_window_sched.sv
// conv_window_sched
// Sequencer for one streamed convolution layer. Tracks the (row, col) of the
// next pixel to be accepted, decides which accepted pixels complete a K x K
// window, and delays that decision through a PIPE_LAT-deep valid pipeline so
// win_valid/win_last line up with the MAC datapath output. Frames each image
// with start / busy / done.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle frame request, honoured only in IDLE
//   pix_valid  pixel present on the datapath this cycle
//   busy       high in RUN and DRAIN
//   col, row   position of the next pixel to be accepted
//   win_valid  datapath output is a valid window result this cycle
//   win_last   with win_valid, final window of the frame
//   done       one-cycle pulse in the cycle after win_last
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | counters at 0, pixels ignored, waiting for start
// S_RUN   | accepting pixels, pushing hit/last into the valid pipeline
// S_DRAIN | all pixels in, flushing the pipeline until win_last emerges

module conv_window_sched #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 5,
    parameter int PIPE_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pix_valid,
    output logic                     busy,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     win_valid,
    output logic                     win_last,
    output logic                     done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_HIT = CW'(K - 1);
    localparam logic [RW-1:0] ROW_HIT = RW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   col_q, col_nxt;
    logic [RW-1:0]   row_q, row_nxt;
    logic            done_q;
    logic            accept;
    logic            hit_push;
    logic            last_push;

    // bit 0 = hit, bit 1 = last; stage PIPE_LAT-1 drives the outputs
    logic [1:0]      pipe_q [PIPE_LAT];

    assign accept    = (state_q == S_RUN) && pix_valid;
    assign hit_push  = accept && (row_q >= ROW_HIT) && (col_q >= COL_HIT);
    assign last_push = hit_push && (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_comb begin
        state_nxt = state_q;
        col_nxt   = col_q;
        row_nxt   = row_q;
        unique case (state_q)
            S_IDLE: begin
                col_nxt = '0;
                row_nxt = '0;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (pix_valid) begin
                    if (col_q == COL_MAX) begin
                        col_nxt = '0;
                        if (row_q == ROW_MAX) begin
                            row_nxt   = '0;
                            state_nxt = S_DRAIN;
                        end else begin
                            row_nxt = row_q + 1'b1;
                        end
                    end else begin
                        col_nxt = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // win_last is the final pipeline stage, so leaving here on it
                // puts done and IDLE in the very next cycle.
                if (win_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                col_nxt   = '0;
                row_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            col_q   <= col_nxt;
            row_q   <= row_nxt;
            done_q  <= (state_q == S_DRAIN) && win_last;
        end
    end

    // Advances every cycle in every state; idle cycles shift in zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= 2'b00;
            end
        end else begin
            pipe_q[0] <= {last_push, hit_push};
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign win_valid = pipe_q[PIPE_LAT-1][0];
    assign win_last  = pipe_q[PIPE_LAT-1][1];
    assign busy      = (state_q != S_IDLE);
    assign col       = col_q;
    assign row       = row_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Testbench for conv_window_sched. A small 4x4 / K=3 / PIPE_LAT=3 instance
// is checked window by window through a scoreboard; a default-parameter
// instance is run for one full 28x28 frame and its totals are checked.

module tb_conv_window_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       busy, win_valid, win_last, done;
    logic [1:0] col, row;

    logic       start2 = 1'b0;
    logic       pv2 = 1'b0;
    logic       busy2, win_valid2, win_last2, done2;
    logic [4:0] col2, row2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int win_count = 0;
    int win2_cnt = 0;
    int last2_cnt = 0;
    int done2_cnt = 0;
    bit prev_last = 1'b0;

    typedef struct {
        int cyc;
        bit last;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_sched #(.IMG_W(4), .IMG_H(4), .K(3), .PIPE_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .busy(busy), .col(col), .row(row),
        .win_valid(win_valid), .win_last(win_last), .done(done)
    );

    conv_window_sched dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pix_valid(pv2),
        .busy(busy2), .col(col2), .row(row2),
        .win_valid(win_valid2), .win_last(win_last2), .done(done2)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the small DUT presents a window.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (win_valid) begin
                checks++;
                win_count++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_window: win_valid=1 at cyc %0d, none expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.last != win_last) begin
                        errors++;
                        $display("FAIL window: got cyc %0d last %0d expected cyc %0d last %0d",
                                 cyc, win_last, e.cyc, e.last);
                    end
                end
            end else if (win_last) begin
                checks++;
                errors++;
                $display("FAIL last_without_valid: win_last=1 win_valid=0 at cyc %0d", cyc);
            end
            if (done || prev_last) begin
                checks++;
                if (done != prev_last || busy) begin
                    errors++;
                    $display("FAIL done_timing: done=%0d busy=%0d expected done=%0d busy=0 (cyc %0d)",
                             done, busy, prev_last, cyc);
                end
            end
            prev_last = win_valid && win_last;

            if (win_valid2) win2_cnt++;
            if (win_valid2 && win_last2) last2_cnt++;
            if (done2) done2_cnt++;
        end else begin
            prev_last = 1'b0;
        end
    end

    // Expected hits in the 4x4 frame with K=3: pixels (2,2),(2,3),(3,2),(3,3).
    function automatic bit is_hit(input int idx);
        return (idx == 10) || (idx == 11) || (idx == 14) || (idx == 15);
    endfunction

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk(name, got, 1);
    endtask

    // Ends at the negedge of the done cycle, so a following call issues
    // start inside the done cycle.
    task automatic run_frame(input bit gap, input bit start_mid);
        int w0;
        exp_t e;
        w0 = win_count;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int idx = 0; idx < 16; idx++) begin
            chk("row", row, idx / 4);
            chk("col", col, idx % 4);
            chk("busy_run", busy, 1);
            pix_valid = 1'b1;
            if (start_mid && idx == 7) start = 1'b1;
            @(posedge clk); #1;
            pix_valid = 1'b0;
            start = 1'b0;
            if (is_hit(idx)) begin
                e.cyc  = cyc + 2;
                e.last = (idx == 15);
                exp_q.push_back(e);
            end
            if (gap) begin
                @(posedge clk); #1;
            end
        end
        chk("busy_drain", busy, 1);
        chk("row_after_frame", row, 0);
        chk("col_after_frame", col, 0);
        wait_done("done_seen");
        chk("windows_per_frame", win_count - w0, 4);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_last", win_last, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        pix_valid = 1'b1;
        pv2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_rowcol", {row, col}, 0);
            chk("idle_win_valid", win_valid, 0);
            chk("idle_done", done, 0);
        end
        pix_valid = 1'b0;
        pv2 = 1'b0;
        chk("idle_busy2", busy2, 0);
        repeat (2) @(posedge clk);
        #1;

        // Continuous frame, then bubbled frame, then start-while-busy
        run_frame(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        run_frame(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        run_frame(1'b0, 1'b1);
        // Start issued in the done cycle: back-to-back frame
        run_frame(1'b0, 1'b0);
        @(posedge clk); #1;

        // Reset while a hit is in flight
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int idx = 0; idx <= 10; idx++) begin
            pix_valid = 1'b1;
            @(posedge clk); #1;
            pix_valid = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rowcol", {row, col}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("postrst_win_valid", win_valid, 0);
            chk("postrst_busy", busy, 0);
        end
        run_frame(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Default 28x28 / K=5 frame
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("busy2_after_start", busy2, 1);
        pv2 = 1'b1;
        repeat (784) @(posedge clk);
        #1;
        pv2 = 1'b0;
        begin
            bit got2;
            got2 = 1'b0;
            for (int t = 0; t < 20 && !got2; t++) begin
                @(negedge clk);
                if (done2) got2 = 1'b1;
            end
            chk("done2_seen", got2, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("full_frame_windows", win2_cnt, 576);
        chk("full_frame_last", last2_cnt, 1);
        chk("full_frame_done", done2_cnt, 1);
        chk("full_frame_idle", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
